// File: rtl/acumulador_produtos.sv
// acumulador_produtos
// Sums a group of unsigned products coming from the sequential multiplier and
// hands the group total to the next stage. The sum saturates to all ones, with
// a sticky overflow flag.
//
// State table:
//   OCIOSO     | waiting for the first product of a group
//   ACUMULANDO | group open, adding products
//   ENTREGA    | result held on the outputs until the consumer takes it
//
// Ports:
//   clock          rising-edge clock
//   start          asynchronous active-high reset
//   produto        unsigned product from the multiplier
//   produto_valido produto is valid this cycle
//   ultimo         with produto_valido: this product closes the group
//   entrada_pronta block accepts a product this cycle
//   soma           group total, saturated
//   contagem       number of products in the group
//   estouro        sticky: the group sum did not fit in LARG_SOMA bits
//   saida_valida   soma/contagem/estouro hold a completed group
//   saida_aceita   consumer takes the result
module acumulador_produtos #(
  parameter int LARG_PROD  = 16,
  parameter int LARG_SOMA  = 24,
  parameter int MAX_TERMOS = 16
) (
  input  logic                             clock,
  input  logic                             start,
  input  logic [LARG_PROD-1:0]             produto,
  input  logic                             produto_valido,
  input  logic                             ultimo,
  output logic                             entrada_pronta,
  output logic [LARG_SOMA-1:0]             soma,
  output logic [$clog2(MAX_TERMOS+1)-1:0]  contagem,
  output logic                             estouro,
  output logic                             saida_valida,
  input  logic                             saida_aceita
);

  localparam int LARG_CONT = $clog2(MAX_TERMOS + 1);
  localparam logic [LARG_CONT-1:0] MAX_CONT = LARG_CONT'(MAX_TERMOS);

  typedef enum logic [1:0] {
    OCIOSO,
    ACUMULANDO,
    ENTREGA
  } estado_t;

  estado_t estado;

  logic                 transfere;
  logic [LARG_SOMA:0]   produto_ext;
  logic [LARG_SOMA:0]   soma_ampla;
  logic [LARG_CONT-1:0] contagem_prox;

  // entrada_pronta is registered and is exactly "not in ENTREGA", so it is the
  // acceptance qualifier as well as the output.
  assign transfere     = produto_valido & entrada_pronta;
  assign produto_ext   = (LARG_SOMA + 1)'(produto);
  // One extra bit so the carry-out shows the overflow.
  assign soma_ampla    = {1'b0, soma} + produto_ext;
  assign contagem_prox = contagem + LARG_CONT'(1);

  always_ff @(posedge clock or posedge start) begin
    if (start) begin
      estado         <= OCIOSO;
      soma           <= '0;
      contagem       <= '0;
      estouro        <= 1'b0;
      saida_valida   <= 1'b0;
      entrada_pronta <= 1'b1;
    end else begin
      case (estado)
        OCIOSO: begin
          if (transfere) begin
            soma     <= produto_ext[LARG_SOMA-1:0];
            contagem <= LARG_CONT'(1);
            estouro  <= 1'b0;
            if (ultimo || (MAX_CONT == LARG_CONT'(1))) begin
              estado         <= ENTREGA;
              entrada_pronta <= 1'b0;
              saida_valida   <= 1'b1;
            end else begin
              estado <= ACUMULANDO;
            end
          end
        end

        ACUMULANDO: begin
          if (transfere) begin
            contagem <= contagem_prox;
            // Once saturated, stay saturated until the group ends.
            if (soma_ampla[LARG_SOMA] || estouro) begin
              soma    <= '1;
              estouro <= 1'b1;
            end else begin
              soma <= soma_ampla[LARG_SOMA-1:0];
            end
            if (ultimo || (contagem_prox == MAX_CONT)) begin
              estado         <= ENTREGA;
              entrada_pronta <= 1'b0;
              saida_valida   <= 1'b1;
            end
          end
        end

        ENTREGA: begin
          // The result registers stay as they are; the next group's first
          // transfer overwrites them.
          if (saida_aceita) begin
            estado         <= OCIOSO;
            saida_valida   <= 1'b0;
            entrada_pronta <= 1'b1;
          end
        end

        default: begin
          estado         <= OCIOSO;
          saida_valida   <= 1'b0;
          entrada_pronta <= 1'b1;
        end
      endcase
    end
  end

endmodule
